// File: rtl/madd_pkg.sv
// Shared definitions for the word-serial wide adder/subtractor.
//   WORD_W       - slice width in bits
//   madd_state_e - sequencer states
//   NAME_*       - ASCII display-name prefixes
//   hex_ascii    - 4-bit value to one uppercase hex ASCII character
package madd_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [0:0] {
    StIdle,
    StCalc
  } madd_state_e;

  localparam logic [31:0] NAME_OP1   = "OP1_";
  localparam logic [31:0] NAME_OP2   = "OP2_";
  localparam logic [31:0] NAME_RES   = "RES_";
  localparam logic [39:0] NAME_FLAGS = "FLAGS";

  function automatic logic [7:0] hex_ascii(input logic [3:0] v);
    if (v < 4'd10) begin
      return 8'h30 + {4'h0, v};
    end else begin
      return 8'h37 + {4'h0, v};  // 8'h37 + 10 = 'A'
    end
  endfunction

endpackage

// File: rtl/add32_slice.sv
// Combinational 32-bit adder slice: {cout_o, sum_o} = a_i + b_i + cin_i.
//   a_i, b_i - operand words
//   cin_i    - carry in
//   sum_o    - 32-bit sum
//   cout_o   - carry out
module add32_slice
  import madd_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};

endmodule

// File: rtl/multiword_adder_display.sv
// Word-serial WORDS x 32-bit adder/subtractor with touchscreen operand entry and
// numbered display slots. One 32-bit slice is summed per clock; the result and carry
// are committed together when the last slice completes.
//   clk, resetn        - clock, synchronous active-low reset
//   input_sel_i        - 0: write operand1, 1: write operand2
//   input_pos_i        - word index of the write (>= WORDS ignored)
//   sw_cin_i, sw_sub_i - carry-in (add mode), subtract select
//   input_valid_i      - one-cycle write strobe
//   input_value_i      - word to write
//   display_number_i   - requested display slot
//   led_cout_o         - committed carry-out (subtract: 1 = no borrow)
//   led_busy_o         - computation pending or in progress
//   display_valid_o/name_o/value_o - registered slot contents, one cycle behind the request
module multiword_adder_display
  import madd_pkg::*;
#(
  parameter int unsigned WORDS = 2,
  localparam int unsigned PW = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              input_sel_i,
  input  logic [PW-1:0]     input_pos_i,
  input  logic              sw_cin_i,
  input  logic              sw_sub_i,
  input  logic              input_valid_i,
  input  logic [WORD_W-1:0] input_value_i,
  input  logic [5:0]        display_number_i,
  output logic              led_cout_o,
  output logic              led_busy_o,
  output logic              display_valid_o,
  output logic [39:0]       display_name_o,
  output logic [WORD_W-1:0] display_value_o
);

  logic [WORD_W-1:0] op1_q    [WORDS];
  logic [WORD_W-1:0] op2_q    [WORDS];
  logic [WORD_W-1:0] work_q   [WORDS];
  logic [WORD_W-1:0] result_q [WORDS];

  madd_state_e   state_q;
  logic [PW-1:0] idx_q;
  logic          req_q, prev_cin_q, prev_sub_q, mode_q, carry_q, cout_q;

  logic              wr_hit, req_set, busy;
  logic [WORD_W-1:0] slice_b, slice_sum;
  logic              slice_cout;

  always_comb begin
    wr_hit  = input_valid_i && (32'(input_pos_i) < WORDS);
    req_set = wr_hit || (sw_cin_i != prev_cin_q) || (sw_sub_i != prev_sub_q);
    busy    = (state_q == StCalc) || req_q;
    // Subtraction is op1 + ~op2 + 1; the +1 comes from the initial carry.
    slice_b = mode_q ? ~op2_q[idx_q] : op2_q[idx_q];
  end

  add32_slice u_slice (
    .a_i   (op1_q[idx_q]),
    .b_i   (slice_b),
    .cin_i (carry_q),
    .sum_o (slice_sum),
    .cout_o(slice_cout)
  );

  // Sequencer, operand registers and commit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      req_q      <= 1'b1;
      prev_cin_q <= sw_cin_i;
      prev_sub_q <= sw_sub_i;
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      for (int unsigned i = 0; i < WORDS; i++) begin
        op1_q[i]    <= '0;
        op2_q[i]    <= '0;
        work_q[i]   <= '0;
        result_q[i] <= '0;
      end
    end else begin
      prev_cin_q <= sw_cin_i;
      prev_sub_q <= sw_sub_i;

      if (wr_hit) begin
        if (input_sel_i) op2_q[input_pos_i] <= input_value_i;
        else             op1_q[input_pos_i] <= input_value_i;
      end

      // A pending request always (re)starts from slice 0, which also aborts a running pass.
      if (req_q) begin
        state_q <= StCalc;
        idx_q   <= '0;
        carry_q <= sw_sub_i | sw_cin_i;
        mode_q  <= sw_sub_i;
        req_q   <= 1'b0;
      end else if (state_q == StCalc) begin
        work_q[idx_q] <= slice_sum;
        carry_q       <= slice_cout;
        if (idx_q == PW'(WORDS - 1)) begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            result_q[i] <= (i == WORDS - 1) ? slice_sum : work_q[i];
          end
          cout_q  <= slice_cout;
          state_q <= StIdle;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end

      // New events win over the clear above, so a write on the commit edge re-triggers.
      if (req_set) req_q <= 1'b1;
    end
  end

  // Display slot decode.
  logic        disp_valid_d, disp_valid_q;
  logic [39:0] disp_name_d, disp_name_q;
  logic [31:0] disp_value_d, disp_value_q;
  logic [31:0] slot, k;

  always_comb begin
    disp_valid_d = 1'b1;
    disp_name_d  = '0;
    disp_value_d = '0;
    slot         = 32'(display_number_i);
    k            = '0;
    if (slot >= 32'd1 && slot <= WORDS) begin
      k            = WORDS - slot;
      disp_name_d  = {NAME_OP1, hex_ascii(4'(k))};
      disp_value_d = op1_q[PW'(k)];
    end else if (slot > WORDS && slot <= 2 * WORDS) begin
      k            = 2 * WORDS - slot;
      disp_name_d  = {NAME_OP2, hex_ascii(4'(k))};
      disp_value_d = op2_q[PW'(k)];
    end else if (slot > 2 * WORDS && slot <= 3 * WORDS) begin
      k            = 3 * WORDS - slot;
      disp_name_d  = {NAME_RES, hex_ascii(4'(k))};
      disp_value_d = result_q[PW'(k)];
    end else if (slot == 3 * WORDS + 1) begin
      disp_name_d  = NAME_FLAGS;
      disp_value_d = {29'b0, mode_q, busy, cout_q};
    end else begin
      disp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      disp_valid_q <= 1'b0;
      disp_name_q  <= '0;
      disp_value_q <= '0;
    end else begin
      disp_valid_q <= disp_valid_d;
      disp_name_q  <= disp_name_d;
      disp_value_q <= disp_value_d;
    end
  end

  assign led_cout_o      = cout_q;
  assign led_busy_o      = busy;
  assign display_valid_o = disp_valid_q;
  assign display_name_o  = disp_name_q;
  assign display_value_o = disp_value_q;

endmodule

// File: tb/tb_multiword_adder_display.sv
module tb_multiword_adder_display;

  localparam int unsigned W  = 3;
  localparam int unsigned PW = $clog2(W);
  localparam int unsigned WB = W * 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          input_sel = 1'b0;
  logic [PW-1:0] input_pos = '0;
  logic          sw_cin = 1'b0;
  logic          sw_sub = 1'b0;
  logic          input_valid = 1'b0;
  logic [31:0]   input_value = '0;
  logic [5:0]    display_number = '0;
  logic          led_cout, led_busy, display_valid;
  logic [39:0]   display_name;
  logic [31:0]   display_value;

  always #5 clk = ~clk;

  multiword_adder_display #(.WORDS(W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .input_sel_i     (input_sel),
    .input_pos_i     (input_pos),
    .sw_cin_i        (sw_cin),
    .sw_sub_i        (sw_sub),
    .input_valid_i   (input_valid),
    .input_value_i   (input_value),
    .display_number_i(display_number),
    .led_cout_o      (led_cout),
    .led_busy_o      (led_busy),
    .display_valid_o (display_valid),
    .display_name_o  (display_name),
    .display_value_o (display_value)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: operands as plain wide integers.
  logic [WB-1:0] m_op1 = '0;
  logic [WB-1:0] m_op2 = '0;

  function automatic logic [WB:0] model(input logic [WB-1:0] a, input logic [WB-1:0] b,
                                        input logic sub, input logic cin);
    if (sub) return {(a >= b), a - b};
    return {1'b0, a} + {1'b0, b} + {{WB{1'b0}}, cin};
  endfunction

  function automatic logic [39:0] str40(input string s);
    logic [39:0] v = '0;
    for (int i = 0; i < 5; i++) v[8*(4-i) +: 8] = s[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sw(input logic sub, input logic cin);
    sw_sub = sub;
    sw_cin = cin;
    tick();
  endtask

  task automatic write_word(input logic sel, input int unsigned pos, input logic [31:0] val);
    input_sel   = sel;
    input_pos   = PW'(pos);
    input_value = val;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    if (pos < W) begin
      if (sel) m_op2[pos*32 +: 32] = val;
      else     m_op1[pos*32 +: 32] = val;
    end
  endtask

  task automatic write_operand(input logic sel, input logic [WB-1:0] v);
    for (int unsigned i = 0; i < W; i++) write_word(sel, i, v[i*32 +: 32]);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (led_busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic read_slot(input int unsigned n, output logic v, output logic [39:0] nm,
                           output logic [31:0] val);
    display_number = 6'(n);
    tick();
    v   = display_valid;
    nm  = display_name;
    val = display_value;
  endtask

  task automatic read_result(output logic [WB-1:0] r);
    logic v;
    logic [39:0] nm;
    logic [31:0] val;
    for (int unsigned k = 0; k < W; k++) begin
      read_slot(3 * W - k, v, nm, val);
      r[k*32 +: 32] = val;
    end
  endtask

  task automatic test_reset();
    int cyc;
    logic [WB-1:0] r;
    resetn = 1'b0;
    tick();
    tick();
    n_checks++; if (led_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", led_cout); end
    n_checks++; if (led_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", led_busy); end
    n_checks++; if (display_valid !== 1'b0 || display_name !== '0 || display_value !== '0) begin
      n_fail++; $display("FAIL reset_display got v=%b n=%h val=%h want all 0", display_valid, display_name, display_value);
    end
    resetn = 1'b1;
    wait_idle(cyc);
    n_checks++; if (cyc !== W + 1) begin n_fail++; $display("FAIL reset_first_pass busy cycles %0d want %0d", cyc, W + 1); end
    read_result(r);
    n_checks++; if (r !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", r); end
  endtask

  task automatic test_add_carry();
    int cyc;
    logic [WB-1:0] r;
    set_sw(1'b0, 1'b0);
    write_operand(1'b1, WB'(1));
    write_operand(1'b0, {WB{1'b1}});
    wait_idle(cyc);
    n_checks++; if (cyc !== W + 1) begin n_fail++; $display("FAIL add_busy_len got %0d want %0d", cyc, W + 1); end
    read_result(r);
    n_checks++; if (r !== '0) begin n_fail++; $display("FAIL add_carry_result got %h want 0", r); end
    n_checks++; if (led_cout !== 1'b1) begin n_fail++; $display("FAIL add_carry_cout got %b want 1", led_cout); end
  endtask

  task automatic test_sub();
    int cyc;
    logic [WB-1:0] r;
    set_sw(1'b1, 1'b0);
    write_operand(1'b0, '0);
    write_operand(1'b1, WB'(1));
    wait_idle(cyc);
    read_result(r);
    n_checks++; if (r !== {WB{1'b1}}) begin n_fail++; $display("FAIL sub_borrow_result got %h want all ones", r); end
    n_checks++; if (led_cout !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_cout got %b want 0", led_cout); end
    write_operand(1'b0, WB'(5));
    write_operand(1'b1, WB'(3));
    wait_idle(cyc);
    read_result(r);
    n_checks++; if (r !== WB'(2)) begin n_fail++; $display("FAIL sub_5_3_result got %h want 2", r); end
    n_checks++; if (led_cout !== 1'b1) begin n_fail++; $display("FAIL sub_5_3_cout got %b want 1", led_cout); end
  endtask

  task automatic test_random();
    int cyc;
    logic [WB-1:0] a, b, r;
    logic [WB:0] exp;
    logic sub, cin;
    for (int t = 0; t < 10; t++) begin
      for (int unsigned i = 0; i < W; i++) begin
        a[i*32 +: 32] = $urandom;
        b[i*32 +: 32] = (t % 3 == 0) ? ~a[i*32 +: 32] : $urandom;
      end
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      set_sw(sub, cin);
      write_operand(1'b0, a);
      write_operand(1'b1, b);
      wait_idle(cyc);
      n_checks++; if (led_busy !== 1'b0) begin n_fail++; $display("FAIL rand_timeout busy=%b after %0d cycles", led_busy, cyc); end
      exp = model(m_op1, m_op2, sub, cin);
      read_result(r);
      n_checks++; if (r !== exp[WB-1:0]) begin n_fail++; $display("FAIL rand_result[%0d] got %h want %h", t, r, exp[WB-1:0]); end
      n_checks++; if (led_cout !== exp[WB]) begin n_fail++; $display("FAIL rand_cout[%0d] got %b want %b", t, led_cout, exp[WB]); end
    end
  endtask

  task automatic test_restart();
    int cyc;
    logic [WB-1:0] r;
    set_sw(1'b0, 1'b0);
    write_operand(1'b0, {WB{1'b1}});
    write_operand(1'b1, WB'(1));
    wait_idle(cyc);
    n_checks++; if (led_cout !== 1'b1) begin n_fail++; $display("FAIL restart_setup_cout got %b want 1", led_cout); end
    // This write alone would commit cout=0; the second write must abort it before commit.
    write_word(1'b0, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (led_cout !== 1'b1) begin n_fail++; $display("FAIL restart_hold_cout cyc %0d got %b want 1", i, led_cout); end
      tick();
    end
    write_word(1'b0, 0, 32'hFFFF_FFFF);
    cyc = 0;
    while (led_busy === 1'b1 && cyc < 100) begin
      n_checks++; if (led_cout !== 1'b1) begin n_fail++; $display("FAIL restart_no_commit cyc %0d got %b want 1", cyc, led_cout); end
      tick();
      cyc++;
    end
    n_checks++; if (cyc !== W + 1) begin n_fail++; $display("FAIL restart_latency got %0d want %0d", cyc, W + 1); end
    read_result(r);
    n_checks++; if (r !== '0) begin n_fail++; $display("FAIL restart_result got %h want 0", r); end
    n_checks++; if (led_cout !== 1'b1) begin n_fail++; $display("FAIL restart_cout got %b want 1", led_cout); end
  endtask

  task automatic test_display_sweep();
    logic [WB:0]  res;
    logic         ev;
    logic [39:0]  en, prev_name;
    logic [31:0]  eval;
    string        s;
    int unsigned  k;
    res = model(m_op1, m_op2, sw_sub, sw_cin);
    display_number = '0;
    tick();
    prev_name = '0;
    for (int unsigned n = 0; n <= 3 * W + 2; n++) begin
      ev = 1'b1; en = '0; eval = '0;
      if (n >= 1 && n <= W) begin
        k = W - n; s = $sformatf("OP1_%1X", k); en = str40(s); eval = m_op1[k*32 +: 32];
      end else if (n > W && n <= 2 * W) begin
        k = 2 * W - n; s = $sformatf("OP2_%1X", k); en = str40(s); eval = m_op2[k*32 +: 32];
      end else if (n > 2 * W && n <= 3 * W) begin
        k = 3 * W - n; s = $sformatf("RES_%1X", k); en = str40(s); eval = res[k*32 +: 32];
      end else if (n == 3 * W + 1) begin
        en = str40("FLAGS"); eval = {29'b0, sw_sub, 1'b0, res[WB]};
      end else begin
        ev = 1'b0;
      end
      display_number = 6'(n);
      #2;
      n_checks++; if (display_name !== prev_name) begin n_fail++; $display("FAIL disp_lag slot %0d got %h want %h", n, display_name, prev_name); end
      tick();
      n_checks++; if (display_valid !== ev) begin n_fail++; $display("FAIL disp_valid slot %0d got %b want %b", n, display_valid, ev); end
      n_checks++; if (display_name !== en) begin n_fail++; $display("FAIL disp_name slot %0d got %h want %h", n, display_name, en); end
      n_checks++; if (display_value !== eval) begin n_fail++; $display("FAIL disp_value slot %0d got %h want %h", n, display_value, eval); end
      prev_name = en;
    end
  endtask

  task automatic test_cin_toggle_and_bad_pos();
    int cyc;
    logic [WB-1:0] r;
    logic v;
    logic [39:0] nm;
    logic [31:0] val;
    set_sw(1'b0, 1'b0);
    write_operand(1'b0, '0);
    write_operand(1'b1, '0);
    wait_idle(cyc);
    sw_cin = 1'b1;
    tick();
    wait_idle(cyc);
    n_checks++; if (cyc !== W + 1) begin n_fail++; $display("FAIL cin_busy_len got %0d want %0d", cyc, W + 1); end
    read_result(r);
    n_checks++; if (r !== WB'(1)) begin n_fail++; $display("FAIL cin_result got %h want 1", r); end
    write_word(1'b0, W, 32'hDEAD_BEEF);
    n_checks++; if (led_busy !== 1'b0) begin n_fail++; $display("FAIL badpos_busy got %b want 0", led_busy); end
    tick();
    n_checks++; if (led_busy !== 1'b0) begin n_fail++; $display("FAIL badpos_busy_late got %b want 0", led_busy); end
    for (int unsigned n = 1; n <= W; n++) begin
      read_slot(n, v, nm, val);
      n_checks++; if (val !== m_op1[(W-n)*32 +: 32]) begin n_fail++; $display("FAIL badpos_op1 slot %0d got %h want %h", n, val, m_op1[(W-n)*32 +: 32]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [WB-1:0] r;
    logic v;
    logic [39:0] nm;
    logic [31:0] val;
    set_sw(1'b0, 1'b1);
    write_operand(1'b1, {WB{1'b1}});
    wait_idle(cyc);
    write_word(1'b0, 0, 32'h1234_5678);
    tick();
    tick();
    resetn = 1'b0;
    tick();
    m_op1 = '0;
    m_op2 = '0;
    n_checks++; if (led_cout !== 1'b0) begin n_fail++; $display("FAIL rstmid_cout got %b want 0", led_cout); end
    n_checks++; if (led_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy got %b want 1", led_busy); end
    n_checks++; if (display_valid !== 1'b0 || display_name !== '0 || display_value !== '0) begin
      n_fail++; $display("FAIL rstmid_display got v=%b n=%h val=%h want all 0", display_valid, display_name, display_value);
    end
    resetn = 1'b1;
    wait_idle(cyc);
    read_result(r);
    n_checks++; if (r !== WB'(1)) begin n_fail++; $display("FAIL rstmid_result got %h want 1", r); end
    n_checks++; if (led_cout !== 1'b0) begin n_fail++; $display("FAIL rstmid_result_cout got %b want 0", led_cout); end
    read_slot(W + 1, v, nm, val);
    n_checks++; if (val !== 32'h0) begin n_fail++; $display("FAIL rstmid_op2_cleared got %h want 0", val); end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_random();
    test_restart();
    test_display_sweep();
    test_cin_toggle_and_bad_pos();
    test_display_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
